// File: rtl/tlb_op_ctrl_if.sv
// Bundle between the TLB op sequencer, CP0/exception side, data-path search and the TLB ports.
// The slave modport is the sequencer; master is everything around it.
interface tlb_op_ctrl_if #(
    parameter int unsigned TLBNUM = 16
);
    localparam int unsigned IDXW = $clog2(TLBNUM);

    logic            op_valid;
    logic [1:0]      op_code;
    logic            op_ready;
    logic            op_done;
    logic [31:0]     cp0_entryhi;
    logic [31:0]     cp0_entrylo0;
    logic [31:0]     cp0_entrylo1;
    logic [IDXW-1:0] cp0_index;
    logic [IDXW-1:0] cp0_wired;
    logic            wired_we;
    logic [IDXW-1:0] random_out;
    logic            res_index_we;
    logic [31:0]     res_index;
    logic            res_entry_we;
    logic [31:0]     res_entryhi;
    logic [31:0]     res_entrylo0;
    logic [31:0]     res_entrylo1;
    logic [18:0]     dp_vpn2;
    logic            dp_odd_page;
    logic [7:0]      dp_asid;
    logic            dp_stall;
    logic [18:0]     s1_vpn2;
    logic            s1_odd_page;
    logic [7:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic [IDXW-1:0] r_index;
    logic [77:0]     r_entry;
    logic            we;
    logic [IDXW-1:0] w_index;
    logic [77:0]     w_entry;

    modport slave (
        input  op_valid, op_code, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
               cp0_wired, wired_we, dp_vpn2, dp_odd_page, dp_asid, s1_found, s1_index, r_entry,
        output op_ready, op_done, random_out, res_index_we, res_index, res_entry_we, res_entryhi,
               res_entrylo0, res_entrylo1, dp_stall, s1_vpn2, s1_odd_page, s1_asid, r_index, we,
               w_index, w_entry
    );

    modport master (
        output op_valid, op_code, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
               cp0_wired, wired_we, dp_vpn2, dp_odd_page, dp_asid, s1_found, s1_index, r_entry,
        input  op_ready, op_done, random_out, res_index_we, res_index, res_entry_we, res_entryhi,
               res_entrylo0, res_entrylo1, dp_stall, s1_vpn2, s1_odd_page, s1_asid, r_index, we,
               w_index, w_entry
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for CP0 TLBP/TLBR/TLBWI/TLBWR: IDLE -> EXEC -> DONE, owns the TLB read/write ports,
// borrows search port 1 during TLBP, and maintains the Random register.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 16
) (
    input logic          clk,
    input logic          rst,
    tlb_op_ctrl_if.slave bus
);
    localparam int unsigned IDXW = $clog2(TLBNUM);
    localparam logic [IDXW-1:0] RandMax = IDXW'(TLBNUM - 1);
    localparam logic [1:0] OpTlbp  = 2'd0;
    localparam logic [1:0] OpTlbr  = 2'd1;
    localparam logic [1:0] OpTlbwr = 2'd3;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [18:0]     vpn2_q, vpn2_d;
    logic [7:0]      asid_q, asid_d;
    logic [IDXW-1:0] random_q, random_d;
    logic            op_done_q, op_done_d;
    logic            we_q, we_d;
    logic            dp_stall_q, dp_stall_d;
    logic            res_index_we_q, res_index_we_d;
    logic            res_entry_we_q, res_entry_we_d;
    logic [31:0]     res_index_q, res_index_d;
    logic [31:0]     res_entryhi_q, res_entryhi_d;
    logic [31:0]     res_entrylo0_q, res_entrylo0_d;
    logic [31:0]     res_entrylo1_q, res_entrylo1_d;
    logic [IDXW-1:0] r_index_q, r_index_d;
    logic [IDXW-1:0] w_index_q, w_index_d;
    logic [77:0]     w_entry_q, w_entry_d;

    logic unused_cp0;
    assign unused_cp0 = ^{bus.cp0_entryhi[12:8], bus.cp0_entrylo0[31:26],
                          bus.cp0_entrylo1[31:26]};

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        vpn2_d         = vpn2_q;
        asid_d         = asid_q;
        op_done_d      = 1'b0;
        we_d           = 1'b0;
        dp_stall_d     = 1'b0;
        res_index_we_d = 1'b0;
        res_entry_we_d = 1'b0;
        res_index_d    = res_index_q;
        res_entryhi_d  = res_entryhi_q;
        res_entrylo0_d = res_entrylo0_q;
        res_entrylo1_d = res_entrylo1_q;
        r_index_d      = r_index_q;
        w_index_d      = w_index_q;
        w_entry_d      = w_entry_q;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    state_d    = StExec;
                    op_d       = bus.op_code;
                    vpn2_d     = bus.cp0_entryhi[31:13];
                    asid_d     = bus.cp0_entryhi[7:0];
                    r_index_d  = bus.cp0_index;
                    dp_stall_d = 1'b1;
                    // Writes are issued straight from the accept edge so we lands in EXEC.
                    if (bus.op_code[1]) begin
                        we_d      = 1'b1;
                        w_index_d = (bus.op_code == OpTlbwr) ? random_q : bus.cp0_index;
                        w_entry_d = {bus.cp0_entryhi[31:13], bus.cp0_entryhi[7:0],
                                     bus.cp0_entrylo0[0] & bus.cp0_entrylo1[0],
                                     bus.cp0_entrylo0[25:6], bus.cp0_entrylo0[5:3],
                                     bus.cp0_entrylo0[2], bus.cp0_entrylo0[1],
                                     bus.cp0_entrylo1[25:6], bus.cp0_entrylo1[5:3],
                                     bus.cp0_entrylo1[2], bus.cp0_entrylo1[1]};
                    end
                end
            end
            StExec: begin
                state_d    = StDone;
                op_done_d  = 1'b1;
                dp_stall_d = op_q[1];
                if (op_q == OpTlbp) begin
                    res_index_we_d = 1'b1;
                    res_index_d    = 32'h8000_0000;
                    if (bus.s1_found) begin
                        res_index_d                = '0;
                        res_index_d[IDXW-1:0]      = bus.s1_index;
                    end
                end
                if (op_q == OpTlbr) begin
                    res_entry_we_d = 1'b1;
                    res_entryhi_d  = {bus.r_entry[77:59], 5'b0, bus.r_entry[58:51]};
                    res_entrylo0_d = {6'b0, bus.r_entry[49:25], bus.r_entry[50]};
                    res_entrylo1_d = {6'b0, bus.r_entry[24:0], bus.r_entry[50]};
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Wired at or above the top entry keeps Random pinned to TLBNUM-1.
    always_comb begin
        random_d = random_q - 1'b1;
        if (bus.wired_we || (random_q <= bus.cp0_wired)) random_d = RandMax;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= '0;
            vpn2_q         <= '0;
            asid_q         <= '0;
            random_q       <= RandMax;
            op_done_q      <= 1'b0;
            we_q           <= 1'b0;
            dp_stall_q     <= 1'b0;
            res_index_we_q <= 1'b0;
            res_entry_we_q <= 1'b0;
            res_index_q    <= '0;
            res_entryhi_q  <= '0;
            res_entrylo0_q <= '0;
            res_entrylo1_q <= '0;
            r_index_q      <= '0;
            w_index_q      <= '0;
            w_entry_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            vpn2_q         <= vpn2_d;
            asid_q         <= asid_d;
            random_q       <= random_d;
            op_done_q      <= op_done_d;
            we_q           <= we_d;
            dp_stall_q     <= dp_stall_d;
            res_index_we_q <= res_index_we_d;
            res_entry_we_q <= res_entry_we_d;
            res_index_q    <= res_index_d;
            res_entryhi_q  <= res_entryhi_d;
            res_entrylo0_q <= res_entrylo0_d;
            res_entrylo1_q <= res_entrylo1_d;
            r_index_q      <= r_index_d;
            w_index_q      <= w_index_d;
            w_entry_q      <= w_entry_d;
        end
    end

    always_comb begin
        bus.s1_vpn2     = bus.dp_vpn2;
        bus.s1_odd_page = bus.dp_odd_page;
        bus.s1_asid     = bus.dp_asid;
        if (state_q == StExec && op_q == OpTlbp) begin
            bus.s1_vpn2     = vpn2_q;
            bus.s1_odd_page = 1'b0;
            bus.s1_asid     = asid_q;
        end
    end

    assign bus.op_ready     = (state_q == StIdle);
    assign bus.op_done      = op_done_q;
    assign bus.random_out   = random_q;
    assign bus.res_index_we = res_index_we_q;
    assign bus.res_index    = res_index_q;
    assign bus.res_entry_we = res_entry_we_q;
    assign bus.res_entryhi  = res_entryhi_q;
    assign bus.res_entrylo0 = res_entrylo0_q;
    assign bus.res_entrylo1 = res_entrylo1_q;
    assign bus.dp_stall     = dp_stall_q;
    assign bus.r_index      = r_index_q;
    assign bus.we           = we_q;
    assign bus.w_index      = w_index_q;
    assign bus.w_entry      = w_entry_q;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a small TLB array answers search/read/write, and a scoreboard queue
// holds the result each accepted op must report when op_done appears.
module tb_tlb_op_ctrl;
    localparam int unsigned TLBNUM = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();
    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } sb_t;

    sb_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  rnd_exp = 4'hF;
    logic [3:0]  last_w = 4'h0;
    logic [77:0] tlb_mem [TLBNUM];
    logic [15:0] tlb_v = '0;

    task automatic check_eq(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [77:0] pack(input logic [31:0] eh, input logic [31:0] lo0,
                                         input logic [31:0] lo1);
        return {eh[31:13], eh[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
    endfunction

    // TLB array: writes on we, combinational search on port 1 and read port.
    always @(posedge clk) begin
        if (bus.we) begin
            tlb_mem[bus.w_index] <= bus.w_entry;
            tlb_v[bus.w_index]   <= 1'b1;
        end
    end

    always_comb begin
        bus.s1_found = 1'b0;
        bus.s1_index = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (tlb_v[i] && tlb_mem[i][77:59] == bus.s1_vpn2 &&
                (tlb_mem[i][50] || tlb_mem[i][58:51] == bus.s1_asid)) begin
                bus.s1_found = 1'b1;
                bus.s1_index = i[3:0];
            end
        end
    end

    assign bus.r_entry = tlb_mem[bus.r_index];

    // Random reference: advance using the inputs the coming edge will sample.
    task automatic tick();
        if (rst || bus.wired_we || rnd_exp <= bus.cp0_wired) rnd_exp = 4'hF;
        else rnd_exp = rnd_exp - 4'd1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.op_done) begin
            if (sb.size() == 0) begin
                check_eq("done_spurious", bus.op_done, 1'b0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                case (e.code)
                    2'd0: check_eq("tlbp_res_index", bus.res_index, e.a);
                    2'd1: begin
                        check_eq("tlbr_entryhi", bus.res_entryhi, e.a);
                        check_eq("tlbr_entrylo0", bus.res_entrylo0, e.b);
                        check_eq("tlbr_entrylo1", bus.res_entrylo1, e.c);
                    end
                    default: check_eq("wr_no_res", {bus.res_index_we, bus.res_entry_we}, 2'b00);
                endcase
            end
        end
    end

    task automatic do_op(input logic [1:0] code, input logic [31:0] eh, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [3:0] idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        logic [3:0] exp_w;
        check_eq("ready_pre", bus.op_ready, 1'b1);
        bus.cp0_entryhi  = eh;
        bus.cp0_entrylo0 = lo0;
        bus.cp0_entrylo1 = lo1;
        bus.cp0_index    = idx;
        bus.op_code      = code;
        bus.op_valid     = 1'b1;
        exp_w            = (code == 2'd3) ? rnd_exp : idx;
        if (code == 2'd3) last_w = rnd_exp;
        sb.push_back('{code, a, b, c});
        tick();
        // EXEC: inputs scrambled to prove the op works from latched values.
        bus.op_valid     = 1'b0;
        bus.cp0_entryhi  = ~eh;
        bus.cp0_entrylo0 = ~lo0;
        bus.cp0_entrylo1 = ~lo1;
        bus.cp0_index    = ~idx;
        #1;
        check_eq("exec_ready", bus.op_ready, 1'b0);
        check_eq("exec_stall", bus.dp_stall, 1'b1);
        check_eq("exec_done", bus.op_done, 1'b0);
        check_eq("exec_we", bus.we, code[1]);
        if (code[1]) begin
            check_eq("exec_w_index", bus.w_index, exp_w);
            check_eq("exec_w_entry", bus.w_entry, pack(eh, lo0, lo1));
        end
        if (code == 2'd0) begin
            check_eq("exec_s1_vpn2", bus.s1_vpn2, eh[31:13]);
            check_eq("exec_s1_odd", bus.s1_odd_page, 1'b0);
            check_eq("exec_s1_asid", bus.s1_asid, eh[7:0]);
        end else begin
            check_eq("exec_s1_pass", {bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid},
                     {bus.dp_vpn2, bus.dp_odd_page, bus.dp_asid});
        end
        if (code == 2'd1) check_eq("exec_r_index", bus.r_index, idx);
        tick();
        check_eq("done_pulse", bus.op_done, 1'b1);
        check_eq("done_we", bus.we, 1'b0);
        check_eq("done_stall", bus.dp_stall, code[1]);
        check_eq("done_res_index_we", bus.res_index_we, code == 2'd0);
        check_eq("done_res_entry_we", bus.res_entry_we, code == 2'd1);
        tick();
        check_eq("post_ready", bus.op_ready, 1'b1);
        check_eq("post_done", bus.op_done, 1'b0);
    endtask

    initial begin
        bus.op_valid     = 1'b0;
        bus.op_code      = 2'd0;
        bus.cp0_entryhi  = '0;
        bus.cp0_entrylo0 = '0;
        bus.cp0_entrylo1 = '0;
        bus.cp0_index    = '0;
        bus.cp0_wired    = '0;
        bus.wired_we     = 1'b0;
        bus.dp_vpn2      = '0;
        bus.dp_odd_page  = 1'b0;
        bus.dp_asid      = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_ready", bus.op_ready, 1'b1);
        check_eq("rst_done", bus.op_done, 1'b0);
        check_eq("rst_we", bus.we, 1'b0);
        check_eq("rst_stall", bus.dp_stall, 1'b0);
        check_eq("rst_res_we", {bus.res_index_we, bus.res_entry_we}, 2'b00);
        check_eq("rst_res_index", bus.res_index, 32'h0);
        check_eq("rst_res_entryhi", bus.res_entryhi, 32'h0);
        check_eq("rst_w", {bus.w_index, bus.w_entry, bus.r_index}, '0);
        check_eq("rst_random", bus.random_out, rnd_exp);

        for (int i = 0; i < 2; i++) begin
            bus.dp_vpn2     = (i == 0) ? 19'h1ABCD : 19'h02468;
            bus.dp_odd_page = (i == 0);
            bus.dp_asid     = (i == 0) ? 8'h5A : 8'hC3;
            #1;
            check_eq("idle_s1_pass", {bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid},
                     {bus.dp_vpn2, bus.dp_odd_page, bus.dp_asid});
            check_eq("idle_stall", bus.dp_stall, 1'b0);
            tick();
        end

        bus.dp_vpn2 = 19'h7FFFF;
        bus.dp_odd_page = 1'b1;
        bus.dp_asid = 8'hAA;
        do_op(2'd2, 32'h0040_2012, 32'h0000_0483, 32'h0000_0001, 4'd5, '0, '0, '0);
        do_op(2'd0, 32'h0040_2033, '0, '0, 4'd0, 32'h0000_0005, '0, '0);
        do_op(2'd0, 32'h1234_0033, '0, '0, 4'd0, 32'h8000_0000, '0, '0);
        do_op(2'd1, 32'h0, '0, '0, 4'd5, 32'h0040_2012, 32'h0000_0483, 32'h0000_0001);

        bus.cp0_wired = 4'd4;
        bus.wired_we  = 1'b1;
        tick();
        bus.wired_we  = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check_eq("rand_seq", bus.random_out, (i < 12) ? 4'(15 - i) : 4'd15);
            tick();
        end
        tick();
        tick();
        check_eq("rand_mid", bus.random_out, 4'd12);
        bus.wired_we = 1'b1;
        tick();
        bus.wired_we = 1'b0;
        check_eq("rand_wired_we", bus.random_out, 4'd15);
        tick();
        tick();

        do_op(2'd3, 32'h0ABC_E044, 32'h0000_1A47, 32'h0000_2C46, 4'd0, '0, '0, '0);
        check_eq("rand_track", bus.random_out, rnd_exp);
        do_op(2'd0, 32'h0ABC_E044, '0, '0, 4'd0, {28'h0, last_w}, '0, '0);
        do_op(2'd0, 32'h0ABC_E045, '0, '0, 4'd0, 32'h8000_0000, '0, '0);

        bus.cp0_entryhi  = 32'h0066_6001;
        bus.cp0_entrylo0 = 32'h0000_0043;
        bus.cp0_entrylo1 = 32'h0000_0043;
        bus.cp0_index    = 4'd7;
        bus.op_code      = 2'd2;
        bus.op_valid     = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        check_eq("abort_exec_we", bus.we, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("abort_we", bus.we, 1'b0);
        check_eq("abort_done", bus.op_done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("abort_ready", bus.op_ready, 1'b1);
        check_eq("abort_we_post", bus.we, 1'b0);
        check_eq("abort_done_post", bus.op_done, 1'b0);
        check_eq("abort_w", {bus.w_index, bus.w_entry}, '0);
        check_eq("abort_res", {bus.res_index, bus.res_entryhi}, '0);
        check_eq("abort_random", bus.random_out, rnd_exp);
        tick();
        tick();
        check_eq("abort_no_done", bus.op_done, 1'b0);
        check_eq("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
